// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared definitions for the pipeline hazard sequencer: jump encodings, FSM states
// and a helper that decodes a MEM-stage control-flow redirect.
package pipe_hazard_ctrl_pkg;

    localparam int unsigned REG_IDX_W = 5;

    localparam logic [1:0] JMP_NONE = 2'b00;
    localparam logic [1:0] JMP_JAL  = 2'b10;
    localparam logic [1:0] JMP_JALR = 2'b11;

    typedef enum logic [1:0] {
        StBoot,
        StRun,
        StWait
    } hz_state_e;

    // The 01 jump encoding is reserved and behaves like no jump.
    function automatic logic is_redirect(input logic taken, input logic [1:0] jump);
        return taken || (jump == JMP_JAL) || (jump == JMP_JALR);
    endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Bundle between the hazard sequencer and the pipeline datapath.
// The master side is the sequencer, the slave side is the datapath.
interface pipe_hazard_ctrl_if #(
    parameter int unsigned CNT_W = 32
);
    import pipe_hazard_ctrl_pkg::*;

    logic [REG_IDX_W-1:0] id_rs1;
    logic [REG_IDX_W-1:0] id_rs2;
    logic                 id_use_rs1;
    logic                 id_use_rs2;
    logic                 ex_memread;
    logic [REG_IDX_W-1:0] ex_rd;
    logic                 mem_taken;
    logic [1:0]           mem_jump;
    logic [31:0]          mem_pc_branch;
    logic [31:0]          mem_jalr_out;
    logic                 dmem_req;
    logic                 dmem_ready;

    logic                 pc_write;
    logic                 redirect;
    logic [31:0]          redirect_pc;
    logic                 if_id_write;
    logic                 if_id_flush;
    logic                 id_ex_flush;
    logic                 ex_mem_flush;
    logic                 pipe_hold;
    logic                 mem_err;
    logic [CNT_W-1:0]     stall_cnt;
    logic [CNT_W-1:0]     flush_cnt;

    modport master (
        input  id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_memread, ex_rd,
        input  mem_taken, mem_jump, mem_pc_branch, mem_jalr_out, dmem_req, dmem_ready,
        output pc_write, redirect, redirect_pc, if_id_write, if_id_flush, id_ex_flush,
        output ex_mem_flush, pipe_hold, mem_err, stall_cnt, flush_cnt
    );

    modport slave (
        output id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_memread, ex_rd,
        output mem_taken, mem_jump, mem_pc_branch, mem_jalr_out, dmem_req, dmem_ready,
        input  pc_write, redirect, redirect_pc, if_id_write, if_id_flush, id_ex_flush,
        input  ex_mem_flush, pipe_hold, mem_err, stall_cnt, flush_cnt
    );

endinterface

// File: rtl/pipe_hazard_ctrl_sat_counter.sv
// Saturating up-counter with synchronous active-low reset and synchronous clear.
module sat_counter #(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             clear,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (inc && (count_q != '1)) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: merges load-use, MEM-stage redirects and
// data-memory waits into pipeline-register controls, with a boot clear and access timeout.
module pipe_hazard_ctrl #(
    parameter int unsigned BOOT_CYCLES = 2,
    parameter int unsigned MEM_TIMEOUT = 64,
    parameter int unsigned CNT_W       = 32
) (
    input logic                clk,
    input logic                rstn,
    pipe_hazard_ctrl_if.master hz
);
    import pipe_hazard_ctrl_pkg::*;

    localparam int unsigned BootW = $clog2(BOOT_CYCLES + 1);
    localparam int unsigned WaitW = $clog2(MEM_TIMEOUT + 1);
    localparam logic [BootW-1:0] BootLast = BootW'(BOOT_CYCLES - 1);
    localparam logic [WaitW-1:0] WaitLast = WaitW'(MEM_TIMEOUT - 1);

    hz_state_e        state_q;
    logic [BootW-1:0] boot_q;
    logic [WaitW-1:0] wait_q;
    logic             mem_err_q;

    logic        mem_stall;
    logic        redir_req;
    logic        load_use;
    logic        pc_write;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        if_id_write;
    logic        if_id_flush;
    logic        id_ex_flush;
    logic        ex_mem_flush;
    logic        pipe_hold;
    logic        in_boot;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    always_comb begin
        mem_stall = hz.dmem_req && !hz.dmem_ready;
        redir_req = is_redirect(hz.mem_taken, hz.mem_jump);
        load_use  = hz.ex_memread && (hz.ex_rd != '0) &&
                    ((hz.id_use_rs1 && (hz.id_rs1 == hz.ex_rd)) ||
                     (hz.id_use_rs2 && (hz.id_rs2 == hz.ex_rd)));
    end

    always_comb begin
        pc_write     = 1'b1;
        redirect     = 1'b0;
        redirect_pc  = '0;
        if_id_write  = 1'b1;
        if_id_flush  = 1'b0;
        id_ex_flush  = 1'b0;
        ex_mem_flush = 1'b0;
        pipe_hold    = 1'b0;
        unique case (state_q)
            StRun: begin
                if (mem_stall) begin
                    pc_write    = 1'b0;
                    if_id_write = 1'b0;
                    pipe_hold   = 1'b1;
                end else if (redir_req) begin
                    // A redirect squashes the instruction that would have caused a load-use stall.
                    redirect     = 1'b1;
                    if_id_flush  = 1'b1;
                    id_ex_flush  = 1'b1;
                    ex_mem_flush = 1'b1;
                    redirect_pc  = (hz.mem_jump == JMP_JALR) ? {hz.mem_jalr_out[31:1], 1'b0}
                                                              : hz.mem_pc_branch;
                end else if (load_use) begin
                    pc_write    = 1'b0;
                    if_id_write = 1'b0;
                    id_ex_flush = 1'b1;
                end
            end
            StWait: begin
                pc_write    = 1'b0;
                if_id_write = 1'b0;
                pipe_hold   = 1'b1;
            end
            default: begin
                pc_write     = 1'b0;
                if_id_write  = 1'b0;
                if_id_flush  = 1'b1;
                id_ex_flush  = 1'b1;
                ex_mem_flush = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q   <= StBoot;
            boot_q    <= '0;
            wait_q    <= '0;
            mem_err_q <= 1'b0;
        end else begin
            unique case (state_q)
                StBoot: begin
                    if (boot_q == BootLast) begin
                        state_q <= StRun;
                        boot_q  <= '0;
                    end else begin
                        boot_q <= boot_q + 1'b1;
                    end
                end
                StRun: begin
                    if (mem_stall) begin
                        state_q <= StWait;
                        wait_q  <= WaitW'(1);
                    end
                end
                StWait: begin
                    // Completion on the final allowed cycle wins over the timeout.
                    if (hz.dmem_ready) begin
                        state_q <= StRun;
                        wait_q  <= '0;
                    end else if (wait_q == WaitLast) begin
                        state_q   <= StRun;
                        wait_q    <= '0;
                        mem_err_q <= 1'b1;
                    end else begin
                        wait_q <= wait_q + 1'b1;
                    end
                end
                default: state_q <= StBoot;
            endcase
        end
    end

    assign in_boot = (state_q == StBoot);

    sat_counter #(
        .CNT_W (CNT_W)
    ) u_stall_cnt (
        .clk   (clk),
        .rstn  (rstn),
        .clear (in_boot),
        .inc   (!in_boot && !pc_write),
        .count (stall_cnt)
    );

    sat_counter #(
        .CNT_W (CNT_W)
    ) u_flush_cnt (
        .clk   (clk),
        .rstn  (rstn),
        .clear (in_boot),
        .inc   (redirect),
        .count (flush_cnt)
    );

    assign hz.pc_write     = pc_write;
    assign hz.redirect     = redirect;
    assign hz.redirect_pc  = redirect_pc;
    assign hz.if_id_write  = if_id_write;
    assign hz.if_id_flush  = if_id_flush;
    assign hz.id_ex_flush  = id_ex_flush;
    assign hz.ex_mem_flush = ex_mem_flush;
    assign hz.pipe_hold    = pipe_hold;
    assign hz.mem_err      = mem_err_q;
    assign hz.stall_cnt    = stall_cnt;
    assign hz.flush_cnt    = flush_cnt;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: vector table plus multi-cycle sequences,
// with expected outputs queued at drive time and compared mid-cycle.
module tb_pipe_hazard_ctrl;
    import pipe_hazard_ctrl_pkg::*;

    localparam int unsigned CW = 4;

    // {pc_write, redirect, if_id_write, if_id_flush, id_ex_flush, ex_mem_flush, pipe_hold}
    localparam logic [6:0] C_BOOT  = 7'b0001110;
    localparam logic [6:0] C_RUN   = 7'b1010000;
    localparam logic [6:0] C_HOLD  = 7'b0000001;
    localparam logic [6:0] C_LU    = 7'b0000100;
    localparam logic [6:0] C_REDIR = 7'b1111110;

    typedef struct {
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic        u1;
        logic        u2;
        logic        mr;
        logic [4:0]  rd;
        logic        tk;
        logic [1:0]  jp;
        logic [31:0] pcb;
        logic [31:0] jalr;
        logic        req;
        logic        rdy;
        logic [6:0]  ctrl;
        logic [31:0] rpc;
    } vec_t;

    typedef struct {
        string          name;
        logic [6:0]     ctrl;
        logic [31:0]    rpc;
        logic           err;
        logic [CW-1:0]  sc;
        logic [CW-1:0]  fc;
    } exp_t;

    logic clk = 1'b0;
    logic rstn = 1'b0;

    pipe_hazard_ctrl_if #(.CNT_W(CW)) hz ();

    pipe_hazard_ctrl #(
        .BOOT_CYCLES (2),
        .MEM_TIMEOUT (4),
        .CNT_W       (CW)
    ) dut (
        .clk  (clk),
        .rstn (rstn),
        .hz   (hz)
    );

    always #5 clk = ~clk;

    exp_t          sb[$];
    int            n_vec = 0;
    int            n_bad = 0;
    logic [CW-1:0] stall_m = '0;
    logic [CW-1:0] flush_m = '0;
    logic          err_m = 1'b0;

    function automatic vec_t mk(input logic [4:0] rs1, input logic [4:0] rs2, input logic u1,
                                input logic u2, input logic mr, input logic [4:0] rd,
                                input logic tk, input logic [1:0] jp, input logic [31:0] pcb,
                                input logic [31:0] jalr, input logic req, input logic rdy,
                                input logic [6:0] ctrl, input logic [31:0] rpc);
        vec_t v;
        v.rs1 = rs1; v.rs2 = rs2; v.u1 = u1; v.u2 = u2; v.mr = mr; v.rd = rd;
        v.tk = tk; v.jp = jp; v.pcb = pcb; v.jalr = jalr; v.req = req; v.rdy = rdy;
        v.ctrl = ctrl; v.rpc = rpc;
        return v;
    endfunction

    function automatic vec_t idle(input logic [6:0] ctrl);
        return mk(0, 0, 0, 0, 0, 0, 0, JMP_NONE, 0, 0, 0, 0, ctrl, 0);
    endfunction

    // Every hazard source at once; must be ignored while booting.
    function automatic vec_t noisy();
        return mk(5, 5, 1, 1, 1, 5, 1, JMP_JALR, 32'h10, 32'h21, 1, 0, C_BOOT, 0);
    endfunction

    task automatic drive(input vec_t v);
        hz.id_rs1 = v.rs1;        hz.id_rs2 = v.rs2;
        hz.id_use_rs1 = v.u1;     hz.id_use_rs2 = v.u2;
        hz.ex_memread = v.mr;     hz.ex_rd = v.rd;
        hz.mem_taken = v.tk;      hz.mem_jump = v.jp;
        hz.mem_pc_branch = v.pcb; hz.mem_jalr_out = v.jalr;
        hz.dmem_req = v.req;      hz.dmem_ready = v.rdy;
    endtask

    task automatic check();
        exp_t       e;
        logic [6:0] act;
        n_vec++;
        if (sb.size() == 0) begin
            n_bad++;
            $display("FAIL scoreboard_empty: no expected entry queued");
            return;
        end
        e = sb.pop_front();
        act = {hz.pc_write, hz.redirect, hz.if_id_write, hz.if_id_flush, hz.id_ex_flush,
               hz.ex_mem_flush, hz.pipe_hold};
        if (act !== e.ctrl || hz.redirect_pc !== e.rpc || hz.mem_err !== e.err ||
            hz.stall_cnt !== e.sc || hz.flush_cnt !== e.fc) begin
            n_bad++;
            $display("FAIL %s: got ctrl=%b rpc=%h err=%b stall=%0d flush=%0d, want ctrl=%b rpc=%h err=%b stall=%0d flush=%0d",
                     e.name, act, hz.redirect_pc, hz.mem_err, hz.stall_cnt, hz.flush_cnt,
                     e.ctrl, e.rpc, e.err, e.sc, e.fc);
        end
    endtask

    // Starts and ends just after a rising edge; outputs are sampled on the falling edge.
    task automatic step(input string name, input vec_t v);
        exp_t e;
        drive(v);
        e.name = name; e.ctrl = v.ctrl; e.rpc = v.rpc;
        e.err = err_m; e.sc = stall_m; e.fc = flush_m;
        sb.push_back(e);
        if (!v.ctrl[6] && !v.ctrl[3] && stall_m != '1) stall_m++;
        if (v.ctrl[5] && flush_m != '1) flush_m++;
        @(negedge clk);
        check();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        drive(noisy());
        @(posedge clk);
        #1;
        stall_m = '0;
        flush_m = '0;
        err_m   = 1'b0;
        step("rst_low0", noisy());
        step("rst_low1", noisy());
        rstn = 1'b1;
    endtask

    task automatic boot_seq();
        step("boot0", noisy());
        step("boot1", noisy());
        step("boot_done", idle(C_RUN));
    endtask

    initial begin
        vec_t tbl[17];
        tbl[0]  = idle(C_RUN);
        tbl[1]  = mk(0, 5, 0, 1, 1, 5, 0, JMP_NONE, 0, 0, 0, 0, C_LU, 0);
        tbl[2]  = mk(0, 0, 0, 1, 1, 0, 0, JMP_NONE, 0, 0, 0, 0, C_RUN, 0);
        tbl[3]  = mk(7, 0, 1, 0, 1, 7, 0, JMP_NONE, 0, 0, 0, 0, C_LU, 0);
        tbl[4]  = mk(7, 0, 0, 0, 1, 7, 0, JMP_NONE, 0, 0, 0, 0, C_RUN, 0);
        tbl[5]  = mk(0, 9, 0, 1, 0, 9, 0, JMP_NONE, 0, 0, 0, 0, C_RUN, 0);
        tbl[6]  = mk(0, 0, 0, 0, 0, 0, 0, JMP_JALR, 32'hDEAD_BEEF, 32'h0000_1003, 0, 0,
                     C_REDIR, 32'h0000_1002);
        tbl[7]  = mk(0, 5, 0, 1, 1, 5, 0, JMP_JALR, 32'h0, 32'h0000_2001, 0, 0,
                     C_REDIR, 32'h0000_2000);
        tbl[8]  = mk(0, 0, 0, 0, 0, 0, 0, JMP_JAL, 32'h400, 32'h777, 0, 0, C_REDIR, 32'h400);
        tbl[9]  = mk(0, 0, 0, 0, 0, 0, 1, JMP_NONE, 32'h80, 32'h91, 0, 0, C_REDIR, 32'h80);
        tbl[10] = mk(0, 0, 0, 0, 0, 0, 0, 2'b01, 32'h123, 32'h555, 0, 0, C_RUN, 0);
        tbl[11] = mk(0, 0, 0, 0, 0, 0, 1, JMP_JALR, 32'h900, 32'h3005, 0, 0,
                     C_REDIR, 32'h3004);
        tbl[12] = mk(0, 0, 0, 0, 0, 0, 0, JMP_NONE, 0, 0, 1, 1, C_RUN, 0);
        tbl[13] = mk(0, 0, 0, 0, 0, 0, 1, JMP_NONE, 32'h44, 0, 1, 1, C_REDIR, 32'h44);
        tbl[14] = mk(0, 0, 0, 0, 0, 0, 1, JMP_NONE, 32'h48, 0, 1, 0, C_HOLD, 0);
        tbl[15] = mk(0, 0, 0, 0, 0, 0, 1, JMP_NONE, 32'h48, 0, 1, 1, C_HOLD, 0);
        tbl[16] = idle(C_RUN);

        drive(noisy());
        @(posedge clk);
        #1;

        // Reset, then a reset one cycle into boot must restart the full boot window.
        do_reset();
        boot_seq();
        do_reset();
        step("boot_partial", noisy());
        do_reset();
        boot_seq();

        for (int i = 0; i < 17; i++) begin
            step($sformatf("tbl%0d", i), tbl[i]);
        end

        // Three wait cycles then ready; redirect held off until back in RUN.
        do_reset();
        boot_seq();
        step("wait_enter", mk(0, 0, 0, 0, 0, 0, 0, JMP_NONE, 0, 0, 1, 0, C_HOLD, 0));
        step("wait_redir1", mk(0, 5, 0, 1, 1, 5, 1, JMP_NONE, 32'h60, 0, 1, 0, C_HOLD, 0));
        step("wait_redir2", mk(0, 0, 0, 0, 0, 0, 1, JMP_NONE, 32'h60, 0, 1, 0, C_HOLD, 0));
        step("wait_ready", mk(0, 0, 0, 0, 0, 0, 1, JMP_NONE, 32'h60, 0, 1, 1, C_HOLD, 0));
        step("wait_redir_run", mk(0, 0, 0, 0, 0, 0, 1, JMP_NONE, 32'h60, 0, 0, 0,
                                  C_REDIR, 32'h60));
        step("wait_after", idle(C_RUN));

        // Timeout: four hold cycles without ready, then sticky error.
        do_reset();
        boot_seq();
        for (int i = 0; i < 4; i++) begin
            step($sformatf("tmo_hold%0d", i),
                 mk(0, 0, 0, 0, 0, 0, 0, JMP_NONE, 0, 0, 1, 0, C_HOLD, 0));
        end
        err_m = 1'b1;
        step("tmo_run0", idle(C_RUN));
        step("tmo_run1", idle(C_RUN));

        // Reset while in WAIT clears the error and counters.
        step("rw_enter", mk(0, 0, 0, 0, 0, 0, 0, JMP_NONE, 0, 0, 1, 0, C_HOLD, 0));
        step("rw_wait", mk(0, 0, 0, 0, 0, 0, 0, JMP_NONE, 0, 0, 1, 0, C_HOLD, 0));
        do_reset();
        boot_seq();

        // Counter saturation.
        for (int i = 0; i < 20; i++) begin
            step($sformatf("sat_lu%0d", i), mk(3, 0, 1, 0, 1, 3, 0, JMP_NONE, 0, 0, 0, 0,
                                               C_LU, 0));
        end
        for (int i = 0; i < 17; i++) begin
            step($sformatf("sat_br%0d", i), mk(0, 0, 0, 0, 0, 0, 1, JMP_NONE, 32'hC0, 0, 0, 0,
                                               C_REDIR, 32'hC0));
        end
        step("sat_final", idle(C_RUN));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
